// File: rtl/stream_mux_pkg.sv
// Shared defaults and arbitration-mode encodings for the stream multiplexer.
package stream_mux_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_NCH   = 8;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/stream_mux_if.sv
// Multi-channel input side and single-channel output side of the stream mux.
interface stream_mux_if
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH
);
    localparam int unsigned SELW = $clog2(NCH);

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/stream_mux_arb.sv
// Fixed-priority / round-robin arbiter; the round-robin pointer advances on every
// transfer regardless of mode so a switch to round-robin resumes after the last winner.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [NCH-1:0]  req,
    input  logic            advance,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     start;
    int unsigned     c;

    // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        start = (mode == MODE_RR) ? int'(ptr_q) : 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            c = (start + k) % NCH;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = SELW'(c);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (idx == SELW'(NCH - 1)) ? '0 : idx + SELW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with a one-entry registered output stage that
// sustains one word per cycle when popped and loaded in the same cycle.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    stream_mux_if.slave bus
);

    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  idx;
    logic             can_accept;
    logic             xfer;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;

    stream_mux_arb #(
        .NCH (NCH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .req     (bus.in_valid),
        .advance (xfer),
        .grant   (grant),
        .idx     (idx)
    );

    assign can_accept   = !out_valid_q | bus.out_ready;
    // Gated by rst so no handshake can complete while the register is held clear.
    assign bus.in_ready = rst ? '0 : (grant & {NCH{can_accept}});
    assign xfer         = |(bus.in_valid & bus.in_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[idx*WIDTH +: WIDTH];
            out_sel_d   = idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 16, data width per channel in bits.
REQ-002 Parameter NCH, default 8, channel count; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(NCH), width of the channel index; derived, not overridden.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 mode  input  1  arbitration policy: 0 = fixed priority, lowest index wins; 1 = round-robin.
REQ-007 in_valid  input  NCH  per-channel request; bit i belongs to channel i.
REQ-008 in_data  input  NCH*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  NCH  per-channel accept; at most one bit high in any cycle.
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_sel  output  SELW  index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 Output stage: one-entry register; can_accept = !out_valid | out_ready, combinational.
REQ-015 Grant: combinational one-hot over in_valid, per mode, computed every cycle; no grant when in_valid == 0.
REQ-016 in_ready[i] = grant[i] & can_accept; in_ready never depends on in_valid of other channels beyond arbitration.
REQ-017 Transfer on channel i when in_valid[i] & in_ready[i]; next cycle out_valid=1, out_data=in_data[i], out_sel=i; latency exactly 1 cycle.
REQ-018 Output pop when out_valid & out_ready; with no simultaneous transfer, out_valid clears next cycle.
REQ-019 Simultaneous pop and transfer: register reloads with the new word; out_valid stays 1; full throughput of 1 word/cycle.
REQ-020 Stall (out_valid & !out_ready): out_data, out_sel, out_valid held stable; all in_ready low.
REQ-021 Fixed priority (mode=0): grant lowest-index valid channel.
REQ-022 Round-robin (mode=1): pointer ptr (SELW bits); grant first valid channel searching ptr, ptr+1, ... wrapping modulo NCH.
REQ-023 ptr updates only on a transfer: ptr <= granted index + 1, wrapping NCH-1 -> 0; unchanged otherwise.
REQ-024 ptr is also updated on transfers in mode=0, so switching to mode=1 resumes after the last served channel.
REQ-025 mode sampled combinationally; a change affects the grant in the same cycle, never a word already in the register.
REQ-026 Non-power-of-two NCH: ptr never holds a value >= NCH.
REQ-027 Upstream rule: in_data[i] must be stable while in_valid[i] is high and in_ready[i] is low; the block does not check this.

Reset
REQ-028 rst high: out_valid=0, out_data=0, out_sel=0, ptr=0 immediately, independent of clk.
REQ-029 in_ready shall be all-zero while rst is high.
REQ-030 Reset mid-transfer discards the registered word; no partial output after release.
REQ-031 First arbitration occurs on the first rising clk edge after rst deasserts.

Structure
REQ-032 Package stream_mux_pkg holds the WIDTH/NCH defaults and the mode encodings MODE_FIXED=0 and MODE_RR=1.
REQ-033 Sub-module stream_mux_arb (parameter NCH) holds the grant logic and ptr; inputs: clk, rst, mode, req, advance; output: one-hot grant and encoded index.
REQ-034 The top holds the output register and the data select; the select is driven by the encoded index.

Verification
REQ-035 Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_sel=0, in_ready=0 without a clk edge.
REQ-036 mode=0, in_valid=8'b1010_0100, out_ready=1 -> channel 2 served every cycle; channels 5 and 7 starve while channel 2 stays valid.
REQ-037 mode=1, all 8 valid, out_ready=1, in_data[i]=16'h00i0 -> out_sel sequence 0,1,...,7,0 on consecutive cycles; out_data matches.
REQ-038 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_sel frozen, in_ready=0; on release, 1 word/cycle resumes with none lost or duplicated.
REQ-039 mode=1, ptr=7 after serving ch6, in_valid=8'b0000_0011 -> ch0 granted, then ch1; ptr wraps 7->0 correctly.
REQ-040 NCH=5, WIDTH=8, mode=1, random valid/ready for 10k cycles -> scoreboard matches, ptr<5 always, in_ready one-hot-or-zero.
